muldiv_sequencer: RTL

- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Sequences MULT/MULTU/DIV/DIVU iteratively: shift-add multiply, restoring divide, one bit per cycle.
- Owns the architectural HI/LO registers.
- Exposes a start/busy/done handshake so the pipeline control can stall on MFHI/MFLO until a result is ready.

---
 rtl/muldiv_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide at one bit per cycle, with a start/busy/done handshake for the pipeline.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int unsigned AW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, ZDIV} state_e;

   state_e             state_q, state_d;
   logic               div_q, div_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               signed_op;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     sum;
   logic [WIDTH+1:0]   shifted, diff;
   logic               borrow;
   logic [AW-1:0]      prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   // Operand magnitudes for the signed ops; the unit works on unsigned values
   assign signed_op = ~op[0];
   assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

   // Multiply step: conditionally add multiplicand into the upper half, then shift right
   assign sum = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

   // Divide step: shift the next dividend bit into the remainder and trial-subtract
   assign shifted = {rem_q, acc_q[WIDTH-1]};
   assign diff    = shifted - {2'b00, opnd_q};
   assign borrow  = diff[WIDTH+1];

   assign prod_fix = neg_lo_q ? -acc_q : acc_q;
   assign quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_hi_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      a_d      = a_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               div_d  = op[1];
               a_d    = a;
               cnt_d  = '0;
               rem_d  = '0;
               busy_d = 1'b1;
               if (op[1]) begin
                  acc_d    = {{WIDTH{1'b0}}, abs_a};
                  opnd_d   = abs_b;
                  neg_lo_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi_d = signed_op & a[WIDTH-1];
                  state_d  = (b == '0) ? ZDIV : CALC;
               end else begin
                  acc_d    = {{WIDTH{1'b0}}, abs_b};
                  opnd_d   = abs_a;
                  neg_lo_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi_d = 1'b0;
                  state_d  = CALC;
               end
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end
         CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
               acc_d = {acc_q[AW-1:WIDTH], acc_q[WIDTH-2:0], ~borrow};
               rem_d = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
            end else begin
               acc_d = {sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
         end
         FIXUP: begin
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[AW-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         ZDIV: begin
            hi_d    = a_q;
            lo_d    = {WIDTH{1'b1}};
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         div_q    <= 1'b0;
         a_q      <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         a_q      <= a_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
